mem_responder_model: RTL and testbench
======================================

MEM_RESPONDER_MODEL -- requirements
Module: mem_responder_model

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10, meaning log2 of the number of 512-bit memory lines.
REQ-002 SHALL have parameter LATENCY, default 4, meaning read-response latency in cycles; legal range is 1..16.
REQ-003 SHALL have parameter LOG_RESP_DEPTH, default 3, meaning log2 of the maximum number of outstanding reads.
REQ-004 SHALL have port clk, input, 1 bit, the clock.
REQ-005 SHALL have port rst, input, 1 bit; reset is rst, synchronous, active-high, on clock clk.
REQ-006 SHALL have port mem_req_in, input, MemReq (valid, isWrite, addr[63:0], data[511:0]), the request from the initiator.
REQ-007 SHALL have port mem_req_grant_out, output, 1 bit, request accepted this cycle.
REQ-008 SHALL have port mem_resp_out, output, MemResp (valid, data[511:0]), the read response.
REQ-009 SHALL have port mem_resp_grant_in, input, 1 bit, initiator consumes the response this cycle.
REQ-010 SHALL have port stat_reads_out, output, 32 bits, count of accepted reads.
REQ-011 SHALL have port stat_writes_out, output, 32 bits, count of accepted writes.
REQ-012 SHALL have port outstanding_out, output, LOG_RESP_DEPTH+1 bits, reads accepted but not yet consumed.

Function
REQ-013 A request SHALL transfer in any cycle where mem_req_in.valid and mem_req_grant_out are both 1; there SHALL be at most one transfer per cycle.
REQ-014 mem_req_grant_out SHALL be combinational: 1 when outstanding_out < 2^LOG_RESP_DEPTH and rst=0, otherwise 0, for reads and writes alike.
REQ-015 mem_req_grant_out SHALL NOT depend on mem_req_in.valid.
REQ-016 Line index SHALL be addr[5+ADDR_BITS:6]; addr[5:0] SHALL be ignored; higher address bits SHALL be ignored, so addresses wrap modulo 2^ADDR_BITS lines.
REQ-017 An accepted write SHALL store all 512 data bits at the line index on the acceptance edge.
REQ-018 An accepted write SHALL generate no response.
REQ-019 An accepted read SHALL sample the line as of the acceptance edge: a write accepted in an earlier cycle is visible, and no read and write can occur in the same cycle.
REQ-020 Read data SHALL traverse a non-stalling LATENCY-stage valid/data pipeline into a show-ahead response FIFO of depth 2^LOG_RESP_DEPTH.
REQ-021 With an empty FIFO, mem_resp_out.valid SHALL first assert exactly LATENCY cycles after the acceptance cycle.
REQ-022 Responses SHALL be returned in acceptance order.
REQ-023 mem_resp_out.valid SHALL equal FIFO not-empty, and mem_resp_out.data SHALL be the FIFO head.
REQ-024 A response SHALL be dequeued when mem_resp_out.valid=1 and mem_resp_grant_in=1; grant while not valid SHALL be ignored.
REQ-025 mem_resp_out SHALL hold valid and data stable until consumed.
REQ-026 outstanding_out SHALL increment on a read transfer and decrement on a response dequeue; both in the same cycle leaves it unchanged.
REQ-027 The credit rule in REQ-014 SHALL guarantee the pipeline never finds the FIFO full; FIFO overflow SHALL be impossible.
REQ-028 The FIFO SHALL support simultaneous enqueue and dequeue, both when full and when empty (no bypass; an entry becomes visible the cycle after it is written).
REQ-029 stat_reads_out and stat_writes_out SHALL increment by 1 per accepted request and wrap modulo 2^32.

Reset
REQ-030 While rst=1: mem_req_grant_out=0, mem_resp_out.valid=0, mem_resp_out.data=0, all pipeline valids cleared, FIFO emptied, outstanding_out=0, and both stat counters=0.
REQ-031 Reset mid-operation SHALL discard all in-flight and queued responses without emitting them.
REQ-032 Memory contents SHALL NOT be cleared by reset; in simulation they initialise to 0.
REQ-033 The first request SHALL be grantable in the first cycle after rst deasserts.

Verification
REQ-034 Write 0xA5..A5 to addr 0x40, then read addr 0x40 with resp_grant held 1 -> resp valid 4 cycles after read acceptance, data 0xA5..A5, stat_writes=1, stat_reads=1.
REQ-035 Write line to addr 0x7 (offset ignored) and to addr 0x10000 (ADDR_BITS=10 wrap to line 0), read addr 0x0 -> returns the second write's data.
REQ-036 Hold resp_grant=0 and issue continuous reads -> exactly 8 accepted, grant then 0, outstanding_out=8; release resp_grant -> 8 responses in order, then grant returns.
REQ-037 Steady back-to-back reads of lines 0..31 with resp_grant=1 -> one accept per cycle, 32 in-order responses, no gaps after the first.
REQ-038 Assert rst for 1 cycle with 5 reads outstanding -> no further responses, outstanding_out=0, counters 0; a subsequent read of a prior write returns the retained data.
REQ-039 Assert resp_grant on the same cycle as a new read while full (outstanding=8) -> grant stays 0 that cycle (combinational on registered count) and goes 1 the next cycle with outstanding=7.

Source files
------------

// File: rtl/mem_responder_model.sv
// Behavioural 512-bit-line memory responder with fixed read latency and a credit-limited,
// in-order response FIFO.
package mem_responder_pkg;
    typedef struct packed {
        logic         valid;
        logic         isWrite;
        logic [63:0]  addr;
        logic [511:0] data;
    } MemReq;

    typedef struct packed {
        logic         valid;
        logic [511:0] data;
    } MemResp;
endpackage

module mem_responder_model
    import mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_BITS      = 10,
    parameter int unsigned LATENCY        = 4,
    parameter int unsigned LOG_RESP_DEPTH = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  MemReq                     mem_req_in,
    output logic                      mem_req_grant_out,
    output MemResp                    mem_resp_out,
    input  logic                      mem_resp_grant_in,
    output logic [31:0]               stat_reads_out,
    output logic [31:0]               stat_writes_out,
    output logic [LOG_RESP_DEPTH:0]   outstanding_out
);
    localparam int unsigned                DEPTH     = 1 << LOG_RESP_DEPTH;
    localparam logic [LOG_RESP_DEPTH:0]    DEPTH_CNT = (LOG_RESP_DEPTH + 1)'(DEPTH);

    logic [511:0]              r_mem [1 << ADDR_BITS];
    logic [511:0]              r_fifo [DEPTH];
    logic [LOG_RESP_DEPTH:0]   r_wr_ptr, r_rd_ptr;
    logic [LOG_RESP_DEPTH:0]   r_outstanding;
    logic [31:0]               r_stat_reads, r_stat_writes;

    logic [ADDR_BITS-1:0]      w_line_idx;
    logic                      w_xfer, w_rd_xfer, w_wr_xfer;
    logic [511:0]              w_rd_data;
    logic                      w_fifo_wr;
    logic [511:0]              w_fifo_wdata;
    logic                      w_empty, w_resp_valid, w_deq;
    logic                      w_unused_addr;

    assign w_line_idx    = mem_req_in.addr[ADDR_BITS+5:6];
    assign w_unused_addr = ^{mem_req_in.addr[63:ADDR_BITS+6], mem_req_in.addr[5:0]};

    // Credits cover both pipeline and FIFO, so the FIFO can never be written while full.
    assign mem_req_grant_out = ~rst & (r_outstanding < DEPTH_CNT);
    assign w_xfer            = mem_req_in.valid & mem_req_grant_out;
    assign w_rd_xfer         = w_xfer & ~mem_req_in.isWrite;
    assign w_wr_xfer         = w_xfer & mem_req_in.isWrite;
    assign w_rd_data         = r_mem[w_line_idx];

    always_ff @(posedge clk) begin
        if (w_wr_xfer) begin
            r_mem[w_line_idx] <= mem_req_in.data;
        end
    end

    // The FIFO write is the last latency stage, so LATENCY-1 registers precede it.
    if (LATENCY == 1) begin : g_no_pipe
        assign w_fifo_wr    = w_rd_xfer;
        assign w_fifo_wdata = w_rd_data;
    end else begin : g_pipe
        logic [LATENCY-2:0] r_pipe_valid;
        logic [511:0]       r_pipe_data [LATENCY-1];

        always_ff @(posedge clk) begin
            if (rst) begin
                r_pipe_valid <= '0;
            end else begin
                r_pipe_valid[0] <= w_rd_xfer;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    r_pipe_valid[i] <= r_pipe_valid[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            r_pipe_data[0] <= w_rd_data;
            for (int i = 1; i < LATENCY - 1; i++) begin
                r_pipe_data[i] <= r_pipe_data[i-1];
            end
        end

        assign w_fifo_wr    = r_pipe_valid[LATENCY-2];
        assign w_fifo_wdata = r_pipe_data[LATENCY-2];
    end

    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_resp_valid = ~rst & ~w_empty;
    assign w_deq        = w_resp_valid & mem_resp_grant_in;

    always_ff @(posedge clk) begin
        if (w_fifo_wr) begin
            r_fifo[r_wr_ptr[LOG_RESP_DEPTH-1:0]] <= w_fifo_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_outstanding <= '0;
            r_stat_reads  <= '0;
            r_stat_writes <= '0;
        end else begin
            if (w_fifo_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_deq)     r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_rd_xfer, w_deq})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
            if (w_rd_xfer) r_stat_reads  <= r_stat_reads + 32'd1;
            if (w_wr_xfer) r_stat_writes <= r_stat_writes + 32'd1;
        end
    end

    assign mem_resp_out    = {w_resp_valid,
                              w_resp_valid ? r_fifo[r_rd_ptr[LOG_RESP_DEPTH-1:0]] : 512'd0};
    assign outstanding_out = r_outstanding;
    assign stat_reads_out  = r_stat_reads;
    assign stat_writes_out = r_stat_writes;
endmodule

// File: tb/tb_mem_responder_model.sv
// Directed self-checking bench for mem_responder_model with default parameters.
module tb_mem_responder_model;
    import mem_responder_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    MemReq       req;
    logic        req_grant;
    MemResp      resp;
    logic        resp_grant;
    logic [31:0] stat_reads, stat_writes;
    logic [3:0]  outstanding;

    int n_tests = 0;
    int n_fail  = 0;

    mem_responder_model #(
        .ADDR_BITS      (10),
        .LATENCY        (4),
        .LOG_RESP_DEPTH (3)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_req_in        (req),
        .mem_req_grant_out (req_grant),
        .mem_resp_out      (resp),
        .mem_resp_grant_in (resp_grant),
        .stat_reads_out    (stat_reads),
        .stat_writes_out   (stat_writes),
        .outstanding_out   (outstanding)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] pat(input logic [31:0] x);
        return {16{x}};
    endfunction

    // Helpers start and end just after a falling edge and assume the request is granted.
    task automatic write_line(input logic [63:0] a, input logic [511:0] d);
        req = '{valid: 1'b1, isWrite: 1'b1, addr: a, data: d};
        @(negedge clk);
        req.valid = 1'b0;
    endtask

    task automatic read_line(input logic [63:0] a, output logic [511:0] d, output bit ok);
        ok = 1'b0;
        d  = '0;
        resp_grant = 1'b1;
        req = '{valid: 1'b1, isWrite: 1'b0, addr: a, data: '0};
        @(negedge clk);
        req.valid = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (resp.valid) begin
                d  = resp.data;
                ok = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        resp_grant = 1'b0;
        req = '0;
        repeat (3) @(negedge clk);
        n_tests++; if (req_grant !== 1'b0) begin n_fail++;
            $display("FAIL rst_grant: got %0h expected 0", req_grant); end
        n_tests++; if (resp.valid !== 1'b0) begin n_fail++;
            $display("FAIL rst_resp_valid: got %0h expected 0", resp.valid); end
        n_tests++; if (resp.data !== 512'd0) begin n_fail++;
            $display("FAIL rst_resp_data: got %0h expected 0", resp.data); end
        n_tests++; if (outstanding !== 4'd0) begin n_fail++;
            $display("FAIL rst_outstanding: got %0d expected 0", outstanding); end
        n_tests++; if ({stat_reads, stat_writes} !== 64'd0) begin n_fail++;
            $display("FAIL rst_stats: got %0d/%0d expected 0/0", stat_reads, stat_writes); end
        rst = 1'b0;
        #1;
        n_tests++; if (req_grant !== 1'b1) begin n_fail++;
            $display("FAIL grant_after_rst: got %0h expected 1", req_grant); end
    endtask

    task automatic test_write_read();
        write_line(64'h40, {64{8'hA5}});
        resp_grant = 1'b1;
        req = '{valid: 1'b1, isWrite: 1'b0, addr: 64'h40, data: '0};
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) req.valid = 1'b0;
            n_tests++; if (resp.valid !== (k == 4)) begin n_fail++;
                $display("FAIL latency_k%0d: got %0h expected %0h", k, resp.valid, (k == 4)); end
        end
        n_tests++; if (resp.data !== {64{8'hA5}}) begin n_fail++;
            $display("FAIL rd_data_a5: got %0h expected %0h", resp.data, {64{8'hA5}}); end
        @(negedge clk);
        n_tests++; if (resp.valid !== 1'b0 || outstanding !== 4'd0) begin n_fail++;
            $display("FAIL single_resp: got valid=%0h outst=%0d expected 0/0",
                     resp.valid, outstanding); end
        n_tests++; if (stat_reads !== 32'd1 || stat_writes !== 32'd1) begin n_fail++;
            $display("FAIL stats_1_1: got %0d/%0d expected 1/1", stat_reads, stat_writes); end
    endtask

    task automatic test_addr_wrap();
        logic [511:0] d;
        bit ok;
        write_line(64'h7, pat(32'h1111_0007));
        write_line(64'h1_0000, pat(32'h2222_0400));
        read_line(64'h0, d, ok);
        n_tests++; if (ok !== 1'b1 || d !== pat(32'h2222_0400)) begin n_fail++;
            $display("FAIL addr_wrap: got ok=%0h %0h expected %0h", ok, d, pat(32'h2222_0400)); end
        read_line(64'h40, d, ok);
        n_tests++; if (ok !== 1'b1 || d !== {64{8'hA5}}) begin n_fail++;
            $display("FAIL line1_untouched: got %0h expected %0h", d, {64{8'hA5}}); end
    endtask

    task automatic test_credit();
        int accepted = 0;
        for (int i = 0; i < 8; i++) write_line(64'(i) << 6, pat(32'hC0DE_0000 + i));
        resp_grant = 1'b0;
        req = '{valid: 1'b1, isWrite: 1'b0, addr: 64'h0, data: '0};
        for (int cyc = 0; cyc < 12; cyc++) begin
            req.addr = 64'(accepted) << 6;
            if (req_grant) accepted++;
            @(negedge clk);
        end
        req.valid = 1'b0;
        n_tests++; if (accepted !== 8) begin n_fail++;
            $display("FAIL credit_accepts: got %0d expected 8", accepted); end
        n_tests++; if (req_grant !== 1'b0) begin n_fail++;
            $display("FAIL credit_grant_low: got %0h expected 0", req_grant); end
        n_tests++; if (outstanding !== 4'd8) begin n_fail++;
            $display("FAIL credit_outstanding: got %0d expected 8", outstanding); end
        n_tests++; if (resp.valid !== 1'b1 || resp.data !== pat(32'hC0DE_0000)) begin n_fail++;
            $display("FAIL credit_head: got %0h expected %0h", resp.data, pat(32'hC0DE_0000)); end
        @(negedge clk);
        n_tests++; if (resp.valid !== 1'b1 || resp.data !== pat(32'hC0DE_0000)) begin n_fail++;
            $display("FAIL head_stable: got %0h expected %0h", resp.data, pat(32'hC0DE_0000)); end
    endtask

    task automatic test_full_grant();
        logic [511:0] exp_q [8];
        int j = 0;
        for (int i = 0; i < 7; i++) exp_q[i] = pat(32'hC0DE_0001 + i);
        exp_q[7] = pat(32'hC0DE_0000);
        resp_grant = 1'b1;
        req = '{valid: 1'b1, isWrite: 1'b0, addr: 64'h0, data: '0};
        #1;
        n_tests++; if (req_grant !== 1'b0) begin n_fail++;
            $display("FAIL full_same_cycle_grant: got %0h expected 0", req_grant); end
        @(negedge clk);
        n_tests++; if (outstanding !== 4'd7 || req_grant !== 1'b1) begin n_fail++;
            $display("FAIL full_next_cycle: got outst=%0d grant=%0h expected 7/1",
                     outstanding, req_grant); end
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (cyc == 1) req.valid = 1'b0;
            if (resp.valid) begin
                if (j < 8) begin
                    n_tests++; if (resp.data !== exp_q[j]) begin n_fail++;
                        $display("FAIL drain_order_%0d: got %0h expected %0h",
                                 j, resp.data, exp_q[j]); end
                end
                j++;
            end
            @(negedge clk);
        end
        n_tests++; if (j !== 8) begin n_fail++;
            $display("FAIL drain_count: got %0d expected 8", j); end
        n_tests++; if (outstanding !== 4'd0 || req_grant !== 1'b1) begin n_fail++;
            $display("FAIL drain_final: got outst=%0d grant=%0h expected 0/1",
                     outstanding, req_grant); end
    endtask

    task automatic test_back_to_back();
        int issued = 0, rcv = 0, gaps = 0, gnt_miss = 0;
        for (int i = 0; i < 32; i++) write_line(64'(i) << 6, pat(32'hB000_0000 + i));
        resp_grant = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (issued < 32) req = '{valid: 1'b1, isWrite: 1'b0, addr: 64'(issued) << 6,
                                     data: '0};
            else req.valid = 1'b0;
            if (req.valid && !req_grant) gnt_miss++;
            else if (req.valid) issued++;
            if (resp.valid) begin
                n_tests++; if (resp.data !== pat(32'hB000_0000 + rcv)) begin n_fail++;
                    $display("FAIL b2b_data_%0d: got %0h expected %0h",
                             rcv, resp.data, pat(32'hB000_0000 + rcv)); end
                rcv++;
            end else if (rcv > 0 && rcv < 32) begin
                gaps++;
            end
            @(negedge clk);
        end
        n_tests++; if (gnt_miss !== 0 || issued !== 32) begin n_fail++;
            $display("FAIL b2b_accepts: got issued=%0d stalls=%0d expected 32/0",
                     issued, gnt_miss); end
        n_tests++; if (rcv !== 32) begin n_fail++;
            $display("FAIL b2b_resp_count: got %0d expected 32", rcv); end
        n_tests++; if (gaps !== 0) begin n_fail++;
            $display("FAIL b2b_gaps: got %0d expected 0", gaps); end
    endtask

    task automatic test_reset_mid();
        logic [511:0] d;
        bit ok;
        int seen = 0;
        write_line(64'(5) << 6, pat(32'h5A5A_0005));
        resp_grant = 1'b0;
        req = '{valid: 1'b1, isWrite: 1'b0, addr: 64'(5) << 6, data: '0};
        repeat (5) @(negedge clk);
        req.valid = 1'b0;
        n_tests++; if (outstanding !== 4'd5) begin n_fail++;
            $display("FAIL mid_outstanding_5: got %0d expected 5", outstanding); end
        rst = 1'b1;
        #1;
        n_tests++; if (req_grant !== 1'b0 || resp.valid !== 1'b0) begin n_fail++;
            $display("FAIL mid_rst_outputs: got grant=%0h valid=%0h expected 0/0",
                     req_grant, resp.valid); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++; if (outstanding !== 4'd0) begin n_fail++;
            $display("FAIL mid_outstanding_0: got %0d expected 0", outstanding); end
        n_tests++; if ({stat_reads, stat_writes} !== 64'd0) begin n_fail++;
            $display("FAIL mid_stats: got %0d/%0d expected 0/0", stat_reads, stat_writes); end
        resp_grant = 1'b1;
        repeat (10) begin
            if (resp.valid) seen++;
            @(negedge clk);
        end
        n_tests++; if (seen !== 0) begin n_fail++;
            $display("FAIL mid_no_stale_resp: got %0d expected 0", seen); end
        read_line(64'(5) << 6, d, ok);
        n_tests++; if (ok !== 1'b1 || d !== pat(32'h5A5A_0005)) begin n_fail++;
            $display("FAIL mid_retained: got ok=%0h %0h expected %0h",
                     ok, d, pat(32'h5A5A_0005)); end
        n_tests++; if (stat_reads !== 32'd1 || stat_writes !== 32'd0) begin n_fail++;
            $display("FAIL mid_stats_after: got %0d/%0d expected 1/0", stat_reads, stat_writes); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        req = '0;
        resp_grant = 1'b0;
        test_reset();
        test_write_read();
        test_addr_wrap();
        test_credit();
        test_full_grant();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
